// File: rtl/sdram_cache_pkg.sv
// Shared types and sizing helpers for the direct-mapped SDRAM read cache.
// Users of this package compute IDX/TAG from the same two defaults.
package sdram_cache_pkg;

    localparam int DEFAULT_LINES     = 256;
    localparam int DEFAULT_ADDR_BITS = 21;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_FILL,
        ST_WRITE
    } state_t;

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int addr_bits, input int lines);
        return addr_bits - 2 - $clog2(lines);
    endfunction

endpackage

// File: rtl/sdram_read_cache_if.sv
// CPU-side native bus, SDRAM-side bus, flush and statistics of the read cache.
// slave = the cache itself, master = whatever drives it (CPU + SDRAM bridge).
interface sdram_read_cache_if;

    logic        cpu_valid;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;

    logic        mem_valid;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        flush;
    logic [15:0] stat_hits;
    logic [15:0] stat_misses;

    modport slave (
        input  cpu_valid, cpu_wstrb, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata,
        output mem_valid, mem_wstrb, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata,
        input  flush,
        output stat_hits, stat_misses
    );

    modport master (
        output cpu_valid, cpu_wstrb, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata,
        input  mem_valid, mem_wstrb, mem_addr, mem_wdata,
        output mem_ready, mem_rdata,
        output flush,
        input  stat_hits, stat_misses
    );

endinterface

// File: rtl/sdram_cache_ram.sv
// Tag + data line store: one registered read port, one write port with
// four data byte enables and a separate tag enable.
module sdram_cache_ram
    import sdram_cache_pkg::*;
#(
    parameter int LINES = DEFAULT_LINES,
    parameter int TAG_W = tag_bits(DEFAULT_ADDR_BITS, DEFAULT_LINES),
    localparam int IDX  = idx_bits(LINES)
) (
    input  logic             clk,
    input  logic             rd_en_i,
    input  logic [IDX-1:0]   rd_idx_i,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic [IDX-1:0]   wr_idx_i,
    input  logic [3:0]       wr_be_i,
    input  logic             wr_tag_en_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i
);

    logic [TAG_W-1:0] tag_mem [LINES];

    always_ff @(posedge clk) begin
        if (wr_tag_en_i) begin
            tag_mem[wr_idx_i] <= wr_tag_i;
        end
        if (rd_en_i) begin
            rd_tag_o <= tag_mem[rd_idx_i];
        end
    end

    // One narrow array per byte lane keeps each lane a plain EBR with its own write enable.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [LINES];
            logic [7:0] lane_rd_q;

            always_ff @(posedge clk) begin
                if (wr_be_i[gi]) begin
                    lane_mem[wr_idx_i] <= wr_data_i[8*gi +: 8];
                end
                if (rd_en_i) begin
                    lane_rd_q <= lane_mem[rd_idx_i];
                end
            end

            assign rd_data_o[8*gi +: 8] = lane_rd_q;
        end
    endgenerate

endmodule

// File: rtl/sdram_read_cache.sv
// Direct-mapped, write-through, one-word-per-line cache between the PicoRV32
// native bus and the SDRAM bridge. Holds the FSM, valid bits, request latches and counters.
module sdram_read_cache
    import sdram_cache_pkg::*;
#(
    parameter int LINES     = DEFAULT_LINES,
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
    input  logic               clk,
    input  logic               reset,
    sdram_read_cache_if.slave  bus
);

    localparam int IDX   = idx_bits(LINES);
    localparam int TAG_W = tag_bits(ADDR_BITS, LINES);

    state_t           state_q, state_d;
    logic [29:0]      waddr_q, waddr_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             hit_q, hit_d;
    logic [LINES-1:0] valid_q, valid_d;

    logic             cpu_ready_q, cpu_ready_d;
    logic [31:0]      cpu_rdata_q, cpu_rdata_d;
    logic             mem_valid_q, mem_valid_d;
    logic [3:0]       mem_wstrb_q, mem_wstrb_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [15:0]      hits_q, hits_d;
    logic [15:0]      misses_q, misses_d;

    logic             accept;
    logic [IDX-1:0]   idx_q;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] ram_tag;
    logic [31:0]      ram_data;
    logic             lookup_hit;
    logic [3:0]       ram_wr_be;
    logic             ram_wr_tag_en;
    logic [31:0]      ram_wr_data;
    logic             unused_addr_bits;

    assign unused_addr_bits = &{1'b0, bus.cpu_addr[1:0]};

    // Never re-accept the request that is being completed this cycle.
    assign accept     = (state_q == ST_IDLE) && bus.cpu_valid && !cpu_ready_q;
    assign idx_q      = waddr_q[IDX-1:0];
    assign tag_q      = waddr_q[ADDR_BITS-3:IDX];
    assign lookup_hit = valid_q[idx_q] && (ram_tag == tag_q);

    assign ram_wr_data = (state_q == ST_FILL) ? bus.mem_rdata : wdata_q;

    sdram_cache_ram #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_ram (
        .clk         (clk),
        .rd_en_i     (accept),
        .rd_idx_i    (bus.cpu_addr[2+IDX-1:2]),
        .rd_tag_o    (ram_tag),
        .rd_data_o   (ram_data),
        .wr_idx_i    (idx_q),
        .wr_be_i     (ram_wr_be),
        .wr_tag_en_i (ram_wr_tag_en),
        .wr_tag_i    (tag_q),
        .wr_data_i   (ram_wr_data)
    );

    always_comb begin
        state_d       = state_q;
        waddr_d       = waddr_q;
        wstrb_d       = wstrb_q;
        wdata_d       = wdata_q;
        hit_d         = hit_q;
        valid_d       = valid_q;
        cpu_ready_d   = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
        mem_valid_d   = mem_valid_q;
        mem_wstrb_d   = mem_wstrb_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        hits_d        = hits_q;
        misses_d      = misses_q;
        ram_wr_be     = 4'b0000;
        ram_wr_tag_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    waddr_d = bus.cpu_addr[31:2];
                    wstrb_d = bus.cpu_wstrb;
                    wdata_d = bus.cpu_wdata;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (wstrb_q == 4'b0000) begin
                    if (lookup_hit) begin
                        cpu_rdata_d = ram_data;
                        cpu_ready_d = 1'b1;
                        hits_d      = hits_q + 16'd1;
                        state_d     = ST_IDLE;
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_wstrb_d = 4'b0000;
                        mem_addr_d  = {waddr_q, 2'b00};
                        mem_wdata_d = 32'd0;
                        misses_d    = misses_q + 16'd1;
                        state_d     = ST_FILL;
                    end
                end else begin
                    mem_valid_d = 1'b1;
                    mem_wstrb_d = wstrb_q;
                    mem_addr_d  = {waddr_q, 2'b00};
                    mem_wdata_d = wdata_q;
                    hit_d       = lookup_hit;
                    state_d     = ST_WRITE;
                end
            end
            ST_FILL: begin
                if (bus.mem_ready) begin
                    ram_wr_be      = 4'b1111;
                    ram_wr_tag_en  = 1'b1;
                    valid_d[idx_q] = 1'b1;
                    cpu_rdata_d    = bus.mem_rdata;
                    cpu_ready_d    = 1'b1;
                    mem_valid_d    = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // Write-through; a write miss leaves the line untouched.
                if (bus.mem_ready) begin
                    if (hit_q) begin
                        ram_wr_be = wstrb_q;
                    end
                    cpu_ready_d = 1'b1;
                    mem_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush overrides a fill completing in the same cycle.
        if (bus.flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            waddr_q     <= '0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            hit_q       <= 1'b0;
            valid_q     <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            mem_valid_q <= 1'b0;
            mem_wstrb_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hits_q      <= '0;
            misses_q    <= '0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            hit_q       <= hit_d;
            valid_q     <= valid_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_valid_q <= mem_valid_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hits_q      <= hits_d;
            misses_q    <= misses_d;
        end
    end

    assign bus.cpu_ready   = cpu_ready_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.mem_valid   = mem_valid_q;
    assign bus.mem_wstrb   = mem_wstrb_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.stat_hits   = hits_q;
    assign bus.stat_misses = misses_q;

endmodule

// File: doc/sdram_read_cache.md
# sdram_read_cache

Direct-mapped, write-through, one-word-per-line cache between the PicoRV32 native memory bus and the `sdram` bridge. Read hits complete in two cycles without touching SDRAM. Read misses fetch one word downstream and allocate it. Writes always pass through downstream and update the line only on a hit.

## Interface
- `LINES`, 256: number of lines, power of two; `IDX = log2(LINES)`.
- `ADDR_BITS`, 21: byte-address bits decoded by SDRAM; `TAG = ADDR_BITS-2-IDX`.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `cpu_valid` in 1: CPU request, held until `cpu_ready`.
- `cpu_wstrb` in 4: byte strobes; 0 = read.
- `cpu_addr` in 32: byte address; bits [1:0] ignored.
- `cpu_wdata` in 32: write data.
- `cpu_ready` out 1: one-cycle completion pulse.
- `cpu_rdata` out 32: read data, valid while `cpu_ready`.
- `mem_valid` out 1: downstream request to `sdram`.
- `mem_wstrb` out 4: downstream strobes.
- `mem_addr` out 32: downstream word address, bits [1:0] = 0.
- `mem_wdata` out 32: downstream write data.
- `mem_ready` in 1: downstream completion pulse.
- `mem_rdata` in 32: downstream read data, valid with `mem_ready`.
- `flush` in 1: invalidate all lines.
- `stat_hits` out 16: read-hit counter, wraps.
- `stat_misses` out 16: read-miss counter, wraps.

## Operation
- Address split: index = `cpu_addr[2+IDX-1:2]`, tag = `cpu_addr[ADDR_BITS-1:2+IDX]`. Upper bits are ignored; the upstream decoder selects this block.
- Storage:
  - Valid bits are `LINES` flops, cleared by `reset` or `flush`.
  - Tag and data live in synchronous-read RAM with a byte write enable.
- FSM states: IDLE, LOOKUP, FILL, WRITE.
- IDLE: accepts when `cpu_valid & ~cpu_ready`. It latches addr, wstrb and wdata, issues the RAM read, then goes to LOOKUP. It never accepts in the cycle `cpu_ready` is high.
- LOOKUP: hit = valid[idx] & (tag_ram == tag).
  - Read hit: `cpu_rdata` ← data_ram, `cpu_ready` ← 1, `stat_hits`++, go to IDLE.
  - Read miss: `mem_valid` ← 1 with `mem_wstrb` = 0, `stat_misses`++, go to FILL.
  - Write (any): `mem_valid` ← 1 with latched strobes and data, latch the hit flag, go to WRITE.
- FILL: on `mem_ready`:
  - write tag and data, set valid[idx];
  - `cpu_rdata` ← `mem_rdata`, `cpu_ready` ← 1, `mem_valid` ← 0;
  - go to IDLE.
- WRITE: on `mem_ready`:
  - if the latched hit flag is set, write the strobed bytes of wdata into the data RAM;
  - `cpu_ready` ← 1, `mem_valid` ← 0, go to IDLE.
  - Write misses do not allocate.
- `mem_*` outputs stay constant while `mem_valid` is high.
- `flush`:
  - clears all valid bits at the next edge;
  - a FILL completing in the same cycle leaves its line invalid (flush wins);
  - a LOOKUP in the flush cycle uses the pre-flush valid bits.
- Reset (async, any state):
  - state → IDLE;
  - `cpu_ready`, `mem_valid`, valid bits and counters → 0;
  - `cpu_rdata`, `mem_addr`, `mem_wdata` and `mem_wstrb` → 0.
  - A `mem_ready` arriving in IDLE afterwards is ignored.

## Timing
- All outputs are registered.
- Read hit: `cpu_valid` sampled at edge 0, LOOKUP at edge 1, `cpu_ready` high during cycle 2.
- Miss and write:
  - `mem_valid` rises in cycle 2;
  - if `mem_ready` arrives in cycle k, then `cpu_ready` is high in cycle k+1 and `mem_valid` is low from k+1.
- `cpu_ready` is high for exactly one cycle per accepted request.
- A back-to-back request can be accepted one cycle after `cpu_ready`.
- At most one downstream transaction is outstanding.
- Counter increments land on the LOOKUP edge.

## Structure
- Package `sdram_cache_pkg`:
  - state enum (IDLE, LOOKUP, FILL, WRITE);
  - IDX and TAG width helper functions;
  - default `LINES` and `ADDR_BITS`.
- Sub-module `sdram_cache_ram`:
  - `LINES` × (TAG+32) synchronous-read RAM;
  - one read port, one write port;
  - 4 data byte enables plus a tag enable, suitable for EBR inference.
- Top level holds the FSM, valid flops, request latches and counters.

## Test plan
- Cold read at 0x0000_0100 with `mem_rdata` = 0xDEADBEEF, `mem_ready` after 5 cycles:
  - one `mem_valid` with wstrb 0 and addr 0x100;
  - `cpu_rdata` = 0xDEADBEEF;
  - `stat_misses` = 1.
- Repeat the same read:
  - no `mem_valid`;
  - `cpu_ready` 2 cycles after `cpu_valid`;
  - data 0xDEADBEEF;
  - `stat_hits` = 1.
- Write wstrb 0b0011, data 0x0000_1234 to 0x100 (hit), then read 0x100:
  - downstream write seen with wstrb 0b0011;
  - the following read hits and returns 0xDEAD1234.
- With `LINES` = 256, read 0x100 then 0x500 (same index, different tag), then read 0x100:
  - all three reads miss;
  - `stat_misses` = 3.
- Pulse `flush` after a fill, then re-read:
  - the re-read misses.
- Assert `flush` in the FILL completion cycle:
  - the next read of that address misses.
- Assert `reset` during FILL:
  - `mem_valid` and `cpu_ready` drop immediately;
  - a late `mem_ready` causes no `cpu_ready`;
  - the next read misses.
